// File: rtl/univ_shift_reg.sv
// Universal shift register with hold/load/shift/rotate/clear modes and an
// LSB-first serialiser that circulates dout through WIDTH right-rotations.
module univ_shift_reg #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    input  logic             start,
    output logic [WIDTH-1:0] dout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int              CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_CLR   = 3'b110;
    localparam logic [2:0] MODE_RSVD  = 3'b111;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dout  <= RST_VAL;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dout  <= din;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        case (mode)
                            MODE_HOLD, MODE_RSVD: ;
                            MODE_LOAD: dout <= din;
                            MODE_SHL:  dout <= {dout[WIDTH-2:0], sin};
                            MODE_SHR:  dout <= {sin, dout[WIDTH-1:1]};
                            MODE_ROL:  dout <= {dout[WIDTH-2:0], dout[WIDTH-1]};
                            MODE_ROR:  dout <= {dout[0], dout[WIDTH-1:1]};
                            MODE_CLR:  dout <= '0;
                        endcase
                    end
                end
                SHIFT: begin
                    // WIDTH right-rotations bring dout back to the captured word.
                    dout <= {dout[0], dout[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign sout = busy & dout[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=16: parallel modes,
// serialisation, ignored requests during SHIFT, mid-SHIFT reset, back-to-back runs.
module tb_univ_shift_reg;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       mode;
    logic [WIDTH-1:0] din;
    logic             sin;
    logic             start;
    logic [WIDTH-1:0] dout;
    logic             sout;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    univ_shift_reg #(.WIDTH(WIDTH), .RST_VAL('0)) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .din   (din),
        .sin   (sin),
        .start (start),
        .dout  (dout),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Start a serialisation of value and follow it through to the done cycle.
    task automatic serialise(input logic [WIDTH-1:0] value);
        din   = value;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            check($sformatf("ser_busy[%0d]", i), 64'(busy), 64'd1);
            check($sformatf("ser_sout[%0d]", i), 64'(sout), 64'(value[i]));
            check($sformatf("ser_done_low[%0d]", i), 64'(done), 64'd0);
            step();
        end
        check("ser_end_busy", 64'(busy), 64'd0);
        check("ser_end_done", 64'(done), 64'd1);
        check("ser_end_sout", 64'(sout), 64'd0);
        check("ser_end_dout", 64'(dout), 64'(value));
    endtask

    initial begin
        logic [WIDTH-1:0] word;

        rst = 1'b1; mode = 3'b000; din = '0; sin = 1'b0; start = 1'b0;
        step();
        step();
        check("rst_dout", 64'(dout), 64'h0000);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        step();
        check("idle_dout", 64'(dout), 64'h0000);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        check("idle_sout", 64'(sout), 64'd0);

        mode = 3'b001; din = 16'hA5C3;
        step();
        check("load", 64'(dout), 64'hA5C3);
        mode = 3'b010; sin = 1'b1;
        step();
        check("shl_sin1", 64'(dout), 64'h4B87);
        mode = 3'b101;
        step();
        check("ror", 64'(dout), 64'hA5C3);
        mode = 3'b000;
        step();
        check("hold", 64'(dout), 64'hA5C3);
        mode = 3'b111;
        step();
        check("reserved_hold", 64'(dout), 64'hA5C3);

        mode = 3'b001; din = 16'hF00F;
        step();
        check("load2", 64'(dout), 64'hF00F);
        mode = 3'b011; sin = 1'b0;
        repeat (4) step();
        check("shr_x4", 64'(dout), 64'h0F00);
        mode = 3'b100;
        repeat (4) step();
        check("rol_x4", 64'(dout), 64'hF000);
        check("rol_sout_idle", 64'(sout), 64'd0);
        mode = 3'b110;
        step();
        check("clear", 64'(dout), 64'h0000);
        mode = 3'b000;

        serialise(16'h8001);
        step();
        check("done_one_cycle", 64'(done), 64'd0);
        check("after_ser_dout", 64'(dout), 64'h8001);

        // Requests during SHIFT, and a start on the completing edge, are ignored.
        word  = 16'h1234;
        din   = word;
        start = 1'b1;
        step();
        for (int i = 0; i < WIDTH; i++) begin
            check($sformatf("ign_busy[%0d]", i), 64'(busy), 64'd1);
            check($sformatf("ign_sout[%0d]", i), 64'(sout), 64'(word[i]));
            if (i >= 2 && i < WIDTH - 1) begin
                start = (i % 2 == 0); mode = 3'b001; din = 16'hFFFF;
            end else if (i == WIDTH - 1) begin
                start = 1'b1; mode = 3'b000; din = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        check("ign_end_busy", 64'(busy), 64'd0);
        check("ign_end_done", 64'(done), 64'd1);
        check("ign_end_dout", 64'(dout), 64'h1234);
        step();
        check("ign_no_restart", 64'(busy), 64'd0);
        check("ign_hold_dout", 64'(dout), 64'h1234);
        check("ign_done_low", 64'(done), 64'd0);

        // Reset during the fifth SHIFT cycle aborts without done.
        din   = 16'hBEEF;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check("pre_abort_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_dout", 64'(dout), 64'h0000);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_sout", 64'(sout), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("abort_no_done[%0d]", i), 64'(done), 64'd0);
        end

        serialise(16'h00F1);
        // Back-to-back: start again during the done cycle.
        serialise(16'h5A5A);
        step();
        check("final_done_low", 64'(done), 64'd0);
        check("final_dout", 64'(dout), 64'h5A5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: register width in bits, legal range 2..64.
REQ-002 The block SHALL have parameter RST_VAL, default 0: WIDTH-bit value loaded into dout on reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port mode, input, 3 bits: operation select while idle.
REQ-006 The block SHALL have port din, input, WIDTH bits: parallel data in.
REQ-007 The block SHALL have port sin, input, 1 bit: serial fill bit for shift modes.
REQ-008 The block SHALL have port start, input, 1 bit: request to serialise din onto sout.
REQ-009 The block SHALL have port dout, output, WIDTH bits: registered parallel data out.
REQ-010 The block SHALL have port sout, output, 1 bit: serial data out.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a serialisation is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: registered one-cycle completion pulse.

Function
REQ-013 The block SHALL have exactly two states: IDLE and SHIFT, plus a bit counter cnt of width clog2(WIDTH)+1.
REQ-014 In IDLE with start=0, the block SHALL update dout at each edge according to mode:
- 000: hold.
- 001: dout<=din.
- 010: dout<={dout[WIDTH-2:0],sin}.
- 011: dout<={sin,dout[WIDTH-1:1]}.
- 100: rotate left by 1.
- 101: rotate right by 1.
- 110: dout<=0.
- 111: hold (reserved).
REQ-015 In IDLE with start=1, the block SHALL perform the following at the edge, ignoring mode: dout<=din, cnt<=0, enter SHIFT, busy<=1.
REQ-016 In SHIFT, at each edge the block SHALL rotate dout right by 1 and increment cnt.
REQ-017 When cnt==WIDTH-1 at an edge in SHIFT, the block SHALL perform that final rotate, return to IDLE, set busy<=0 and set done<=1.
REQ-018 busy SHALL be high for exactly WIDTH cycles per serialisation.
REQ-019 After completion, dout SHALL equal the din captured at start, because WIDTH rotations restore it.
REQ-020 sout SHALL equal dout[0] while busy=1 and 0 while busy=0.
- The sout sequence is therefore din[0], din[1], ..., din[WIDTH-1], LSB first, one bit per cycle, beginning the cycle after start is sampled.
REQ-021 done SHALL be high for exactly one cycle, the cycle immediately after busy falls, and low at all other times.
REQ-022 While in SHIFT, start and mode SHALL be ignored; no restart and no queueing occur.
REQ-023 start sampled on the same edge on which SHIFT completes SHALL be ignored; a new start is accepted only from IDLE, one cycle later at the earliest.
REQ-024 Back-to-back serialisations SHALL be possible with one IDLE cycle between them; done of the first overlaps that IDLE cycle.
REQ-025 All outputs SHALL be registered, except sout, which SHALL be combinational from dout[0] and busy.

Reset
REQ-026 When rst=1 at an edge, the block SHALL set dout<=RST_VAL, busy<=0, done<=0 and cnt<=0, and enter IDLE.
REQ-027 rst SHALL take priority over start and mode in every state.
REQ-028 rst asserted mid-SHIFT SHALL abort the serialisation with no done pulse, and sout SHALL be 0 from the following cycle.

Verification
REQ-029 The bench SHALL cover, with WIDTH=16: rst=1 for 2 cycles, then released with mode=000 -> dout=0x0000, busy=0, done=0, sout=0.
REQ-030 The bench SHALL cover: mode=001 with din=0xA5C3 -> dout=0xA5C3; then mode=010 with sin=1 for 1 cycle -> 0x4B87; then mode=101 for 1 cycle -> 0xA5C3.
REQ-031 The bench SHALL cover: mode=011 with sin=0 for 4 cycles from 0xF00F -> 0x0F00; then mode=100 for 4 cycles -> 0xF000; then mode=110 -> 0x0000.
REQ-032 The bench SHALL cover: start=1 with din=0x8001 -> busy high 16 cycles; sout=1,0,...,0,1 (bit 0 first, bit 15 last); done high one cycle after busy falls; dout=0x8001 afterwards.
REQ-033 The bench SHALL cover: start pulsed and mode=001 with din=0xFFFF driven during SHIFT -> both ignored, busy duration still 16, dout returns to the original din.
REQ-034 The bench SHALL cover: rst=1 at cycle 5 of SHIFT -> next cycle dout=RST_VAL, busy=0, sout=0, and done never pulses; a subsequent start then serialises normally.
